mips_multicycle_ctrl: RTL and testbench

Next-generation main control FSM for the multicycle MIPS datapath. It sequences fetch/decode/execute/writeback for an extended opcode set (BNE, ANDI/ORI/SLTI, optional JAL). Memory states wait on a ready/req handshake with a timeout, so the core can run with variable-latency memory. It also provides a retired-instruction counter and sticky error flags, and drives the same datapath muxes and enables as the current decoder.

---
 rtl/mips_multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Memory states wait on mem_ready, with an optional timeout into HALT.
// The FSM also keeps a retired-instruction counter and sticky illegal-op and
// bus-error flags.
// Optional feature: define MCTRL_JAL_EN to decode JAL (op 000011). Without it,
// JAL is treated as an illegal opcode.
module mips_multicycle_ctrl #(
  parameter int unsigned ALUOP_W   = 3,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned RETIRE_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic [1:0]          regdst,
  output logic [1:0]          pcsource,
  output logic [1:0]          memtoreg,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                irwrite,
  output logic                memwrite,
  output logic                regwrite,
  output logic                pcwrite,
  output logic                branch,
  output logic                branch_ne,
  output logic                instr_done,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                illegal_op,
  output logic                bus_err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_JUMP, S_IEXEC, S_IWB, S_JAL, S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef MCTRL_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(5);

  // Count value seen on the last permitted non-ready wait cycle.
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef struct packed {
    logic               mem_req;
    logic               iord;
    logic [1:0]         regdst;
    logic [1:0]         pcsource;
    logic [1:0]         memtoreg;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [ALUOP_W-1:0] aluop;
    logic               irwrite;
    logic               memwrite;
    logic               regwrite;
    logic               pcwrite;
    logic               branch;
    logic               branch_ne;
    logic               instr_done;
  } ctl_t;

  state_e                state_q, state_d;
  logic [TIMEOUT_W-1:0]  wait_q, wait_d;
  logic [RETIRE_W-1:0]   retire_q, retire_d;
  logic                  illegal_q, illegal_d;
  logic                  bus_err_q, bus_err_d;
  ctl_t                  ctl;
  logic                  mem_st;
  logic                  illegal_set;
  logic                  bus_set;

  // Next-state and Moore outputs, with mem_ready gating in the wait states.
  always_comb begin
    ctl         = '0;
    state_d     = state_q;
    mem_st      = 1'b0;
    illegal_set = 1'b0;
    bus_set     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_st      = 1'b1;
        ctl.mem_req = 1'b1;
        ctl.alusrcb = 2'b01;
        if (mem_ready) begin
          ctl.irwrite = 1'b1;
          ctl.pcwrite = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alusrcb = 2'b11;
        case (op)
          OP_RTYPE:                          state_d = S_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
`ifdef MCTRL_JAL_EN
          OP_JAL:                            state_d = S_JAL;
`endif
          default: begin
            illegal_set = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b10;
        ctl.aluop   = ALU_ADD;
        state_d     = (op == OP_LW) ? S_MEMREAD : S_MEMWR;
      end
      S_MEMREAD: begin
        mem_st      = 1'b1;
        ctl.iord    = 1'b1;
        ctl.mem_req = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.regwrite   = 1'b1;
        ctl.memtoreg   = 2'b01;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        mem_st         = 1'b1;
        ctl.iord       = 1'b1;
        ctl.mem_req    = 1'b1;
        ctl.memwrite   = mem_ready;
        ctl.instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctl.alusrca = 1'b1;
        ctl.aluop   = ALU_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.regdst     = 2'b01;
        ctl.regwrite   = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alusrca    = 1'b1;
        ctl.aluop      = ALU_SUB;
        ctl.pcsource   = 2'b01;
        ctl.branch     = (op == OP_BEQ);
        ctl.branch_ne  = (op == OP_BNE);
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctl.pcwrite    = 1'b1;
        ctl.pcsource   = 2'b10;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_IEXEC: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b10;
        case (op)
          OP_ANDI: ctl.aluop = ALU_AND;
          OP_ORI:  ctl.aluop = ALU_OR;
          OP_SLTI: ctl.aluop = ALU_SLT;
          default: ctl.aluop = ALU_ADD;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        ctl.regwrite   = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
`ifdef MCTRL_JAL_EN
      S_JAL: begin
        ctl.pcwrite    = 1'b1;
        ctl.pcsource   = 2'b10;
        ctl.regwrite   = 1'b1;
        ctl.regdst     = 2'b10;
        ctl.memtoreg   = 2'b10;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
`endif
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // The TIMEOUT-th consecutive non-ready cycle abandons the access.
    if ((TIMEOUT != 0) && mem_st && !mem_ready && (wait_q == TO_LAST)) begin
      state_d = S_HALT;
      bus_set = 1'b1;
    end
  end

  // Wait counter restarts on every state change and counts stalled cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)       wait_d = '0;
    else if (mem_st && !mem_ready) wait_d = wait_q + 1'b1;
  end

  // Retire counter and sticky flags.
  always_comb begin
    retire_d  = retire_q + RETIRE_W'(ctl.instr_done);
    illegal_d = illegal_q | illegal_set;
    bus_err_d = bus_err_q | bus_set;
  end

  // State and bookkeeping registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retire_q  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Reset forces every control output low, so mem_req drops immediately.
  assign {mem_req, iord, regdst, pcsource, memtoreg, alusrca, alusrcb, aluop,
          irwrite, memwrite, regwrite, pcwrite, branch, branch_ne,
          instr_done} = reset ? ctl : '0;

  assign retire_count = retire_q;
  assign illegal_op   = illegal_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl (TIMEOUT=4, RETIRE_W=4).
module tb_mips_multicycle_ctrl;

  localparam int unsigned RW = 4;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic [1:0] regdst;
    logic [1:0] pcsource;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       instr_done;
  } outs_t;

  logic          clk, reset, mem_ready;
  logic [5:0]    op;
  logic          mem_req, iord, alusrca, irwrite, memwrite, regwrite, pcwrite;
  logic          branch, branch_ne, instr_done, illegal_op, bus_err;
  logic [1:0]    regdst, pcsource, memtoreg, alusrcb;
  logic [2:0]    aluop;
  logic [RW-1:0] retire_count;
  outs_t         obs;

  outs_t       exp_q[$];
  string       tag_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned retired  = 0;

  mips_multicycle_ctrl #(
    .ALUOP_W(3), .TIMEOUT(4), .TIMEOUT_W(8), .RETIRE_W(RW)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .regdst(regdst), .pcsource(pcsource),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne),
    .instr_done(instr_done), .retire_count(retire_count),
    .illegal_op(illegal_op), .bus_err(bus_err)
  );

  assign obs = {mem_req, iord, regdst, pcsource, memtoreg, alusrca, alusrcb,
                aluop, irwrite, memwrite, regwrite, pcwrite, branch, branch_ne,
                instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t e_fetch(input logic r);
    outs_t o = '0;
    o.mem_req = 1'b1; o.alusrcb = 2'b01; o.irwrite = r; o.pcwrite = r;
    return o;
  endfunction
  function automatic outs_t e_decode();
    outs_t o = '0;
    o.alusrcb = 2'b11;
    return o;
  endfunction
  function automatic outs_t e_memadr();
    outs_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = 3'b000;
    return o;
  endfunction
  function automatic outs_t e_memread();
    outs_t o = '0;
    o.iord = 1'b1; o.mem_req = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_memwb();
    outs_t o = '0;
    o.regwrite = 1'b1; o.memtoreg = 2'b01; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_memwr(input logic r);
    outs_t o = '0;
    o.iord = 1'b1; o.mem_req = 1'b1; o.memwrite = r; o.instr_done = r;
    return o;
  endfunction
  function automatic outs_t e_exec();
    outs_t o = '0;
    o.alusrca = 1'b1; o.aluop = 3'b010;
    return o;
  endfunction
  function automatic outs_t e_aluwb();
    outs_t o = '0;
    o.regdst = 2'b01; o.regwrite = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_branch(input logic ne);
    outs_t o = '0;
    o.alusrca = 1'b1; o.aluop = 3'b001; o.pcsource = 2'b01;
    o.branch = ~ne; o.branch_ne = ne; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_jump();
    outs_t o = '0;
    o.pcwrite = 1'b1; o.pcsource = 2'b10; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_iexec(input logic [2:0] a);
    outs_t o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = a;
    return o;
  endfunction
  function automatic outs_t e_iwb();
    outs_t o = '0;
    o.regwrite = 1'b1; o.instr_done = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_jal();
    outs_t o = '0;
    o.pcwrite = 1'b1; o.pcsource = 2'b10; o.regwrite = 1'b1;
    o.regdst = 2'b10; o.memtoreg = 2'b10; o.instr_done = 1'b1;
    return o;
  endfunction

  task automatic drive(input string tag, input logic [5:0] o, input logic r,
                       input outs_t e);
    op        = o;
    mem_ready = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sample();
    outs_t                  e;
    string                  t;
    logic [$bits(outs_t)-1:0] g, x;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    g = obs;
    x = e;
    n_assert++;
    assert (g === x) else begin
      n_fail++;
      $error("FAIL %s: outputs got %h expected %h", t, g, x);
    end
  endtask

  task automatic cyc(input string tag, input logic [5:0] o, input logic r,
                     input outs_t e);
    drive(tag, o, r, e);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ret();
    chk("retire_count", 32'(retire_count), retired % (32'd1 << RW));
  endtask

  task automatic do_fetch(input logic [5:0] o, input int unsigned dly);
    for (int unsigned i = 0; i < dly; i++) cyc("fetch_wait", o, 1'b0, e_fetch(1'b0));
    cyc("fetch", o, 1'b1, e_fetch(1'b1));
  endtask

  task automatic i_type(input string nm, input logic [5:0] o, input logic [2:0] a);
    do_fetch(o, 0);
    cyc({nm, "_decode"}, o, 1'b0, e_decode());
    cyc({nm, "_iexec"}, o, 1'b1, e_iexec(a));
    cyc({nm, "_iwb"}, o, 1'b0, e_iwb());
    retired++;
    chk_ret();
  endtask

  task automatic j_type();
    do_fetch(6'b000010, 0);
    cyc("j_decode", 6'b000010, 1'b0, e_decode());
    cyc("j_jump", 6'b000010, 1'b0, e_jump());
    retired++;
    chk_ret();
  endtask

  initial begin
    reset = 1'b0; op = 6'b000000; mem_ready = 1'b0;
    // Reset held from time zero: every output low.
    #2;
    drive("in_reset", 6'b000000, 1'b0, '0);
    sample();
    chk("retire_in_reset", 32'(retire_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    cyc("fetch_after_release", 6'b000000, 1'b0, e_fetch(1'b0));
    cyc("fetch_wait2", 6'b000000, 1'b0, e_fetch(1'b0));
    // Reset mid-FETCH wait: mem_req must drop without a clock edge.
    reset = 1'b0;
    drive("midwait_reset", 6'b000000, 1'b0, '0);
    #1;
    sample();
    chk("retire_midreset", 32'(retire_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // LW, three stalled cycles in FETCH and in MEMREAD (ready on the 4th wins).
    do_fetch(6'b100011, 3);
    cyc("lw_decode", 6'b100011, 1'b1, e_decode());
    cyc("lw_memadr", 6'b100011, 1'b0, e_memadr());
    for (int unsigned i = 0; i < 3; i++) cyc("lw_memread_wait", 6'b100011, 1'b0, e_memread());
    cyc("lw_memread", 6'b100011, 1'b1, e_memread());
    chk("bus_err_after_boundary", 32'(bus_err), 32'd0);
    cyc("lw_memwb", 6'b100011, 1'b0, e_memwb());
    retired++;
    chk_ret();

    // SW with one stalled cycle.
    do_fetch(6'b101011, 0);
    cyc("sw_decode", 6'b101011, 1'b0, e_decode());
    cyc("sw_memadr", 6'b101011, 1'b0, e_memadr());
    cyc("sw_memwr_wait", 6'b101011, 1'b0, e_memwr(1'b0));
    cyc("sw_memwr", 6'b101011, 1'b1, e_memwr(1'b1));
    retired++;
    chk_ret();

    // R-type.
    do_fetch(6'b000000, 0);
    cyc("r_decode", 6'b000000, 1'b0, e_decode());
    cyc("r_exec", 6'b000000, 1'b1, e_exec());
    cyc("r_aluwb", 6'b000000, 1'b0, e_aluwb());
    retired++;
    chk_ret();

    // BNE then BEQ.
    do_fetch(6'b000101, 0);
    cyc("bne_decode", 6'b000101, 1'b0, e_decode());
    cyc("bne_branch", 6'b000101, 1'b0, e_branch(1'b1));
    retired++;
    do_fetch(6'b000100, 0);
    cyc("beq_decode", 6'b000100, 1'b0, e_decode());
    cyc("beq_branch", 6'b000100, 1'b1, e_branch(1'b0));
    retired++;
    chk_ret();

    j_type();

    i_type("addi", 6'b001000, 3'b000);
    i_type("andi", 6'b001100, 3'b011);
    i_type("ori",  6'b001101, 3'b100);
    i_type("slti", 6'b001010, 3'b101);
    chk("illegal_before", 32'(illegal_op), 32'd0);

    // Undecoded opcode returns to FETCH and sets the sticky flag.
    do_fetch(6'b111111, 0);
    cyc("illegal_decode", 6'b111111, 1'b0, e_decode());
    chk("illegal_set", 32'(illegal_op), 32'd1);
    cyc("illegal_refetch", 6'b111111, 1'b0, e_fetch(1'b0));
    chk_ret();

    // JAL: decoded only when the feature macro is defined.
    cyc("jal_fetch", 6'b000011, 1'b1, e_fetch(1'b1));
    cyc("jal_decode", 6'b000011, 1'b0, e_decode());
`ifdef MCTRL_JAL_EN
    cyc("jal_state", 6'b000011, 1'b0, e_jal());
    retired++;
`else
    cyc("jal_illegal_refetch", 6'b000011, 1'b0, e_fetch(1'b0));
`endif
    chk("illegal_sticky", 32'(illegal_op), 32'd1);
    chk_ret();

    // Enough jumps to wrap the 4-bit retire counter.
    for (int unsigned i = 0; i < 7; i++) j_type();

    // FETCH timeout: four stalled cycles, then HALT ignores mem_ready.
    for (int unsigned i = 0; i < 3; i++) cyc("to_fetch_wait", 6'b000000, 1'b0, e_fetch(1'b0));
    chk("bus_err_before_timeout", 32'(bus_err), 32'd0);
    cyc("to_fetch_last", 6'b000000, 1'b0, e_fetch(1'b0));
    chk("bus_err_set", 32'(bus_err), 32'd1);
    for (int unsigned i = 0; i < 3; i++) cyc("halt", 6'b000000, 1'b1, '0);
    chk("bus_err_sticky", 32'(bus_err), 32'd1);
    chk_ret();

    // Reset leaves HALT and clears everything.
    reset = 1'b0;
    drive("halt_reset", 6'b000000, 1'b0, '0);
    #1;
    sample();
    retired = 0;
    chk("bus_err_cleared", 32'(bus_err), 32'd0);
    chk("illegal_cleared", 32'(illegal_op), 32'd0);
    chk_ret();
    @(posedge clk); #1;
    reset = 1'b1;
    cyc("fetch_after_halt", 6'b000000, 1'b1, e_fetch(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
